data_mem_lsu: RTL and testbench

- Load/store unit between the execute stage and the 32x8 data memory bank.
- Accepts one load or store request per transaction over a valid/ready handshake and computes the effective address as base + offset.
- Drives the memory bank's r_w/address/data ports and captures load data.
- Returns load results, tagged with the destination register, over a valid/ready response channel.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/data_mem_lsu_if.sv | 32 +++
 rtl/lsu_ea_calc.sv | 23 ++
 rtl/data_mem_lsu.sv | 135 +++++++++++++
 tb/tb_data_mem_lsu.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
//   lsu_state_e : FSM state encoding (idle, issue, wait, response)
//   MEM_READ/MEM_WRITE : encodings of the memory r_w line
//   lsu_req_t : request fields latched at acceptance
package lsu_pkg;

  localparam int unsigned LSU_DATA_W = 8;
  localparam int unsigned LSU_ADDR_W = 5;
  localparam int unsigned LSU_RD_W   = 3;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } lsu_state_e;

  typedef struct packed {
    logic                  we;
    logic [LSU_ADDR_W-1:0] ea;
    logic [LSU_DATA_W-1:0] wdata;
    logic [LSU_RD_W-1:0]   rd;
  } lsu_req_t;

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response channels between the execute stage and the LSU.
//   master : execute side (drives requests, consumes responses)
//   slave  : LSU side (accepts requests, produces responses)
interface data_mem_lsu_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [DATA_W-1:0]           req_base;
  logic [DATA_W-1:0]           req_offset;
  logic [DATA_W-1:0]           req_wdata;
  logic [lsu_pkg::LSU_RD_W-1:0] req_rd;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [DATA_W-1:0]           rsp_data;
  logic [lsu_pkg::LSU_RD_W-1:0] rsp_rd;
  logic                        rsp_fault;

  modport master (
    output req_valid, req_we, req_base, req_offset, req_wdata, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_base, req_offset, req_wdata, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_fault
  );

endinterface

// File: rtl/lsu_ea_calc.sv
// Effective-address adder and bounds compare.
//   base_i, offset_i : operands; offset is two's complement, sum wraps mod 2^DATA_W
//   addr_o           : low ADDR_W bits of the effective address
//   oob_o            : effective address >= MEM_DEPTH
module lsu_ea_calc #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic [DATA_W-1:0] base_i,
  input  logic [DATA_W-1:0] offset_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              oob_o
);

  logic [DATA_W-1:0] ea;

  // Carry out is dropped on purpose: negative offsets rely on the wrap.
  assign ea     = base_i + offset_i;
  assign addr_o = ea[ADDR_W-1:0];
  assign oob_o  = 32'(ea) >= MEM_DEPTH;

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit driving the 32x8 data memory bank.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : request/response channels (slave side)
//   mem_r_w      : 1 = read, 0 = write (memory writes on level while 0)
//   mem_addr_in  : write address;  mem_data_in : write data
//   mem_addr_out : read address;   mem_data_out : read data, valid RD_LAT cycles later
//   busy         : FSM not idle
// Build option LSU_BOUNDS_CHECK_EN: an effective address >= MEM_DEPTH skips the
// memory and returns a faulting response (loads and stores).
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W    = LSU_DATA_W,
  parameter int unsigned ADDR_W    = LSU_ADDR_W,
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_lsu_if.slave     bus,
  output logic              mem_r_w,
  output logic [ADDR_W-1:0] mem_addr_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic              mem_r_w_q, mem_r_w_d;

  logic [ADDR_W-1:0] ea_addr;
  logic              oob;
  logic              fault;

  lsu_ea_calc #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ea_calc (
    .base_i   (bus.req_base),
    .offset_i (bus.req_offset),
    .addr_o   (ea_addr),
    .oob_o    (oob)
  );

`ifdef LSU_BOUNDS_CHECK_EN
  assign fault = oob;
`else
  logic unused_oob;
  assign unused_oob = oob;
  assign fault      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    mem_r_w_d   = MEM_READ;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          req_d       = '{we: bus.req_we, ea: ea_addr, wdata: bus.req_wdata, rd: bus.req_rd};
          rsp_fault_d = fault;
          if (fault) begin
            rsp_data_d = '0;
            state_d    = StResp;
          end else begin
            // Registered so the write strobe covers exactly the ISSUE cycle.
            if (bus.req_we) mem_r_w_d = MEM_WRITE;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (req_q.we) begin
          state_d = StIdle;
        end else begin
          cnt_d   = 2'(RD_LAT - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          rsp_data_d = mem_data_out;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      req_q       <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
      mem_r_w_q   <= MEM_READ;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
      mem_r_w_q   <= mem_r_w_d;
    end
  end

  // Reset forces a read immediately so a store caught in ISSUE never lands.
  assign mem_r_w      = mem_r_w_q | reset;
  assign mem_addr_in  = req_q.ea;
  assign mem_addr_out = req_q.ea;
  assign mem_data_in  = req_q.wdata;

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_rd    = req_q.rd;
  assign bus.rsp_fault = rsp_fault_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu with a level-write, RD_LAT-pipelined memory model.
module tb_data_mem_lsu;

  localparam int unsigned RD_LAT = 2;

  typedef struct {
    logic [7:0] data;
    logic [2:0] rd;
    logic       fault;
    int         lat;
    int         acc_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_init;
  logic       mem_r_w;
  logic [4:0] mem_addr_in, mem_addr_out;
  logic [7:0] mem_data_in, mem_data_out;
  logic       busy;

  data_mem_lsu_if #(.DATA_W(8)) bus ();

  data_mem_lsu #(
    .DATA_W    (8),
    .ADDR_W    (5),
    .MEM_DEPTH (32),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .mem_r_w      (mem_r_w),
    .mem_addr_in  (mem_addr_in),
    .mem_addr_out (mem_addr_out),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] tb_addr(input logic [7:0] b, input logic [7:0] o);
    logic [7:0] ea;
    ea = b + o;
    return ea[4:0];
  endfunction

  function automatic logic tb_fault(input logic [7:0] b, input logic [7:0] o);
`ifdef LSU_BOUNDS_CHECK_EN
    logic [7:0] ea;
    ea = b + o;
    return ea >= 8'd32;
`else
    return (b + o) != (b + o);
`endif
  endfunction

  // Memory bank model: level write, RD_LAT-deep registered read.
  logic [7:0] mem [32];
  logic [7:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 37 + 11);
    end else if (mem_r_w == 1'b0) begin
      mem[mem_addr_in] <= mem_data_in;
    end
    rd_pipe[0] <= mem[mem_addr_out];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data_out = rd_pipe[RD_LAT-1];

  // Scoreboard bookkeeping at the clock edge.
  logic [7:0] sb_mem [32];
  exp_t       sb_q [$];
  int         cyc = 0;
  logic       acc_store_q = 1'b0;
  logic [4:0] exp_waddr;
  logic [7:0] exp_wdata;
  int         last_st_cyc = 0, prev_st_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_init) begin
      for (int i = 0; i < 32; i++) sb_mem[i] <= 8'(i * 37 + 11);
    end
    if (reset) begin
      acc_store_q <= 1'b0;
    end else begin
      acc_store_q <= 1'b0;
      if (acc_store_q) sb_mem[exp_waddr] <= exp_wdata;
      if (bus.req_valid && bus.req_ready) begin
        if (bus.req_we && !tb_fault(bus.req_base, bus.req_offset)) begin
          acc_store_q <= 1'b1;
          exp_waddr   <= tb_addr(bus.req_base, bus.req_offset);
          exp_wdata   <= bus.req_wdata;
          prev_st_cyc <= last_st_cyc;
          last_st_cyc <= cyc;
        end else begin
          sb_q.push_back('{
            data:    tb_fault(bus.req_base, bus.req_offset) ? 8'h00
                     : sb_mem[tb_addr(bus.req_base, bus.req_offset)],
            rd:      bus.req_rd,
            fault:   tb_fault(bus.req_base, bus.req_offset),
            lat:     tb_fault(bus.req_base, bus.req_offset) ? 1 : int'(RD_LAT) + 2,
            acc_cyc: cyc});
        end
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  logic in_rsp  = 1'b0;
  logic hs_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      check_eq("mem_r_w", {31'b0, mem_r_w}, {31'b0, !acc_store_q});
      if (acc_store_q) begin
        check_eq("waddr", {27'b0, mem_addr_in}, {27'b0, exp_waddr});
        check_eq("wdata", {24'b0, mem_data_in}, {24'b0, exp_wdata});
      end
      if (hs_prev) check_eq("rsp_drop", {31'b0, bus.rsp_valid}, 32'd0);
      hs_prev <= 1'b0;
      if (sb_q.size() == 0) begin
        check_eq("rsp_unexpected", {31'b0, bus.rsp_valid}, 32'd0);
      end else if (bus.rsp_valid) begin
        check_eq("rsp_data", {24'b0, bus.rsp_data}, {24'b0, sb_q[0].data});
        check_eq("rsp_rd", {29'b0, bus.rsp_rd}, {29'b0, sb_q[0].rd});
        check_eq("rsp_fault", {31'b0, bus.rsp_fault}, {31'b0, sb_q[0].fault});
        check_eq("req_ready_in_resp", {31'b0, bus.req_ready}, 32'd0);
        if (!in_rsp) check_eq("rsp_latency", cyc - sb_q[0].acc_cyc, sb_q[0].lat);
        in_rsp <= 1'b1;
        if (bus.rsp_ready) begin
          void'(sb_q.pop_front());
          in_rsp  <= 1'b0;
          hs_prev <= 1'b1;
        end
      end
    end else begin
      in_rsp  <= 1'b0;
      hs_prev <= 1'b0;
    end
  end

  task automatic do_req(input logic we, input logic [7:0] base, input logic [7:0] off,
                        input logic [7:0] wd, input logic [2:0] rd);
    int n;
    n = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_base   = base;
    bus.req_offset = off;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("req_accept", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("sb_drain", sb_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check_eq("rst_rsp_data", {24'b0, bus.rsp_data}, 32'd0);
    check_eq("rst_rsp_rd", {29'b0, bus.rsp_rd}, 32'd0);
    check_eq("rst_rsp_fault", {31'b0, bus.rsp_fault}, 32'd0);
    check_eq("rst_mem_r_w", {31'b0, mem_r_w}, 32'd1);
    check_eq("rst_addr_in", {27'b0, mem_addr_in}, 32'd0);
    check_eq("rst_addr_out", {27'b0, mem_addr_out}, 32'd0);
    check_eq("rst_data_in", {24'b0, mem_data_in}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset          = 1'b1;
    mem_init       = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_base   = '0;
    bus.req_offset = '0;
    bus.req_wdata  = '0;
    bus.req_rd     = '0;
    bus.rsp_ready  = 1'b1;
    @(posedge clk);
    #1 mem_init = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();

    // Store then load of the same location.
    @(posedge clk); #1;
    do_req(1'b1, 8'h04, 8'h01, 8'hA5, 3'd0);
    do_req(1'b0, 8'h04, 8'h01, 8'h00, 3'd3);
    drain();

    // Back-to-back stores: one accepted every 2 cycles.
    do_req(1'b1, 8'h08, 8'h00, 8'h11, 3'd0);
    do_req(1'b1, 8'h09, 8'h00, 8'h22, 3'd0);
    check_eq("store_throughput", last_st_cyc - prev_st_cyc, 32'd2);

    // Response stalled for 5 cycles.
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 8'h09, 8'h00, 8'h00, 3'd5);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    drain();

    // Negative offset wraps; address past the bank wraps or faults.
    do_req(1'b1, 8'h02, 8'hFF, 8'h5A, 3'd0);
    do_req(1'b0, 8'h02, 8'hFF, 8'h00, 3'd1);
    do_req(1'b0, 8'h1F, 8'h01, 8'h00, 3'd6);
    do_req(1'b1, 8'h1F, 8'h01, 8'h77, 3'd2);
    do_req(1'b0, 8'h20, 8'hE0, 8'h00, 3'd7);
    drain();

    // Reset during the ISSUE cycle of a store.
    do_req(1'b1, 8'h03, 8'h00, 8'hC3, 3'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_blocks_write", {31'b0, mem_r_w}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    do_req(1'b0, 8'h03, 8'h00, 8'h00, 3'd4);
    drain();

    // Random mixed traffic.
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom_range(0, 7)),
             8'($urandom), 3'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
